// File: rtl/ppm_pkg.sv
// Shared definitions for the 4-ary PPM symbol decoder.
package ppm_pkg;

  typedef enum logic {StIdle, StRun} state_e;

  localparam int unsigned PPM_ORDER     = 4;
  localparam int unsigned BITS_PER_SYM  = 2;
  localparam int unsigned SYMS_PER_BYTE = 4;

endpackage

// File: rtl/ppm_slot_timer.sv
// Cycle/slot/symbol counters for the PPM decoder; held at zero while not running.
module ppm_slot_timer
  import ppm_pkg::*;
#(
  parameter int unsigned SLOT_CYC   = 20,
  parameter int unsigned SAMPLE_OFS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run,
  output logic [1:0] o_slot,
  output logic [1:0] o_sym,
  output logic       o_sample_tick,
  output logic       o_sym_end,
  output logic       o_byte_end
);

  localparam int unsigned CW = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] CycLast  = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] CycSample = CW'(SAMPLE_OFS);
  localparam logic [1:0] SlotLast = 2'(PPM_ORDER - 1);
  localparam logic [1:0] SymLast  = 2'(SYMS_PER_BYTE - 1);

  logic [CW-1:0] r_cyc;
  logic [1:0]    r_slot;
  logic [1:0]    r_sym;

  always_ff @(posedge clk) begin
    if (rst || !i_run) begin
      r_cyc  <= '0;
      r_slot <= '0;
      r_sym  <= '0;
    end else if (r_cyc == CycLast) begin
      r_cyc <= '0;
      if (r_slot == SlotLast) begin
        r_slot <= '0;
        r_sym  <= (r_sym == SymLast) ? 2'd0 : r_sym + 2'd1;
      end else begin
        r_slot <= r_slot + 2'd1;
      end
    end else begin
      r_cyc <= r_cyc + 1'b1;
    end
  end

  assign o_slot        = r_slot;
  assign o_sym         = r_sym;
  assign o_sample_tick = (r_cyc == CycSample);
  assign o_sym_end     = (r_cyc == CycLast) && (r_slot == SlotLast);
  assign o_byte_end    = o_sym_end && (r_sym == SymLast);

endmodule

// File: rtl/ppm_symbol_dec.sv
// Demodulates 4-ary PPM symbols into MSB-first bytes after a frame-start pulse,
// ending each frame with exactly one frame_end or frame_err strobe.
module ppm_symbol_dec
  import ppm_pkg::*;
#(
  parameter int unsigned SLOT_CYC   = 20,
  parameter int unsigned SAMPLE_OFS = 10,
  parameter int unsigned MAX_BYTES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Din,
  input  logic       F_en,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic [4:0] byte_cnt,
  output logic       frame_end,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [4:0] MaxCnt = 5'(MAX_BYTES);

  state_e                  r_state;
  logic [7-BITS_PER_SYM:0] r_shift;
  logic [BITS_PER_SYM-1:0] r_pos;
  logic                    r_seen;
  logic                    r_multi;

  logic                    w_run;
  logic [1:0]              w_slot;
  logic [1:0]              w_sym;
  logic                    w_sample_tick;
  logic                    w_sym_end;
  logic                    w_byte_end;
  logic                    w_pulse_now;
  logic                    w_seen;
  logic                    w_multi;
  logic [BITS_PER_SYM-1:0] w_pos;
  logic [7:0]              w_byte;
  logic [4:0]              w_cnt_next;

  assign w_run = (r_state == StRun);

  ppm_slot_timer #(
    .SLOT_CYC   (SLOT_CYC),
    .SAMPLE_OFS (SAMPLE_OFS)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .i_run         (w_run),
    .o_slot        (w_slot),
    .o_sym         (w_sym),
    .o_sample_tick (w_sample_tick),
    .o_sym_end     (w_sym_end),
    .o_byte_end    (w_byte_end)
  );

  // Fold in a sample landing on the symbol's last cycle (SAMPLE_OFS == SLOT_CYC-1).
  assign w_pulse_now = w_sample_tick && !Din;
  assign w_seen      = r_seen | w_pulse_now;
  assign w_multi     = r_multi | (r_seen & w_pulse_now);
  assign w_pos       = w_pulse_now ? w_slot : r_pos;
  assign w_byte      = {r_shift, w_pos};
  assign w_cnt_next  = byte_cnt + 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_pos      <= '0;
      r_seen     <= 1'b0;
      r_multi    <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      byte_cnt   <= 5'd0;
      frame_end  <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_end  <= 1'b0;
      frame_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (F_en) begin
            r_state  <= StRun;
            busy     <= 1'b1;
            byte_cnt <= 5'd0;
            r_seen   <= 1'b0;
            r_multi  <= 1'b0;
          end
        end
        StRun: begin
          if (w_pulse_now) begin
            r_seen <= 1'b1;
            r_pos  <= w_slot;
            if (r_seen) r_multi <= 1'b1;
          end
          if (w_sym_end) begin
            r_seen  <= 1'b0;
            r_multi <= 1'b0;
            if (w_multi || (!w_seen && (w_sym != 2'd0))) begin
              frame_err <= 1'b1;
              r_state   <= StIdle;
              busy      <= 1'b0;
            end else if (!w_seen) begin
              frame_end <= 1'b1;
              r_state   <= StIdle;
              busy      <= 1'b0;
            end else begin
              r_shift <= w_byte[7-BITS_PER_SYM:0];
              if (w_byte_end) begin
                data_out   <= w_byte;
                data_valid <= 1'b1;
                byte_cnt   <= w_cnt_next;
                if (w_cnt_next == MaxCnt) begin
                  frame_end <= 1'b1;
                  r_state   <= StIdle;
                  busy      <= 1'b0;
                end
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ppm_symbol_dec.sv
// Self-checking bench for ppm_symbol_dec: directed scenarios plus random frames
// checked cycle by cycle against a frame-level timeline model.
module tb_ppm_symbol_dec;

  localparam int SLOT = 4;
  localparam int OFS  = 2;
  localparam int MAXB = 2;
  localparam int SYMC = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst, Din, F_en;
  logic [7:0] data_out;
  logic       data_valid, frame_end, frame_err, busy;
  logic [4:0] byte_cnt;

  // {busy, frame_end, frame_err, data_valid, byte_cnt[4:0], data_out[7:0]}
  typedef logic [16:0] vec_t;

  vec_t       obs_a[0:255];
  vec_t       exp_a[0:255];
  int         n_cyc;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] sym_q[$];
  logic [7:0] g_do;
  logic [4:0] g_cnt;

  ppm_symbol_dec #(
    .SLOT_CYC   (SLOT),
    .SAMPLE_OFS (OFS),
    .MAX_BYTES  (MAXB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Din        (Din),
    .F_en       (F_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .byte_cnt   (byte_cnt),
    .frame_end  (frame_end),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t pack_obs();
    return {busy, frame_end, frame_err, data_valid, byte_cnt, data_out};
  endfunction

  // Builds the expected timeline of one frame from sym_q, then drives it.
  // Cycle 0 carries F_en; cycle k (k>=1) is sampled on the negedge closing it.
  task automatic run_frame(input int rst_cyc, input int fen2_cyc);
    int         np, pos, end_c, nb, s, sl;
    bit         is_err, dv;
    logic [7:0] acc, cur_do;
    logic [3:0] m;
    int         bc[$];
    logic [7:0] bv[$];
    acc = 8'h00; end_c = 0; is_err = 1'b0;
    for (int i = 0; i < 64; i++) begin
      m  = (i < sym_q.size()) ? sym_q[i] : 4'h0;
      np = $countones(m);
      pos = 0;
      for (int j = 0; j < 4; j++) if (m[j]) pos = j;
      if (i % 4 == 0) acc = 8'h00;
      if (np == 1) begin
        acc = acc | 8'(pos << (6 - 2 * (i % 4)));
        if (i % 4 == 3) begin
          bc.push_back(SYMC * (i + 1) + 1);
          bv.push_back(acc);
          if (bc.size() == MAXB) begin
            end_c = SYMC * (i + 1) + 1; is_err = 1'b0;
            break;
          end
        end
      end else begin
        end_c  = SYMC * (i + 1) + 1;
        is_err = !(np == 0 && i % 4 == 0);
        break;
      end
    end
    n_cyc  = end_c + 8;
    cur_do = g_do;
    nb     = 0;
    for (int k = 1; k <= n_cyc; k++) begin
      dv = 1'b0;
      for (int b = 0; b < bc.size(); b++) begin
        if (bc[b] == k) begin cur_do = bv[b]; nb = b + 1; dv = 1'b1; end
      end
      exp_a[k] = {k < end_c, (k == end_c) && !is_err, (k == end_c) && is_err, dv, 5'(nb), cur_do};
      if (rst_cyc > 0 && k > rst_cyc) exp_a[k] = '0;
    end
    if (rst_cyc > 0) begin g_do = 8'h00; g_cnt = 5'd0; end
    else begin g_do = cur_do; g_cnt = 5'(nb); end

    @(posedge clk); #1;
    F_en = 1'b1; rst = 1'b0; Din = 1'b1;
    for (int k = 1; k <= n_cyc; k++) begin
      @(posedge clk); #1;
      F_en = (k == fen2_cyc);
      rst  = (k == rst_cyc);
      if (k >= end_c) begin
        Din = 1'($urandom % 2);
      end else begin
        s  = (k - 1) / SYMC;
        sl = ((k - 1) % SYMC) / SLOT;
        m  = (s < sym_q.size()) ? sym_q[s] : 4'h0;
        Din = !m[sl];
      end
      @(negedge clk);
      obs_a[k] = pack_obs();
    end
    F_en = 1'b0; rst = 1'b0;
  endtask

  task automatic push_syms(input int a, input int b, input int c, input int d);
    sym_q.push_back(4'(1 << a)); sym_q.push_back(4'(1 << b));
    sym_q.push_back(4'(1 << c)); sym_q.push_back(4'(1 << d));
  endtask

  task automatic test_reset();
    rst = 1'b1; Din = 1'b1; F_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (pack_obs() !== 17'h0) begin
      n_fail++;
      $display("FAIL reset: got %h want %h", pack_obs(), 17'h0);
    end
    rst = 1'b0;
    g_do = 8'h00; g_cnt = 5'd0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (pack_obs() !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want %h", pack_obs(), 17'h0);
    end
  endtask

  task automatic test_single_byte();
    bit any_err;
    sym_q.delete(); push_syms(2, 3, 1, 0);
    run_frame(0, 0);
    for (int k = 1; k <= n_cyc; k++) begin
      n_tests++;
      if (obs_a[k] !== exp_a[k]) begin
        n_fail++;
        $display("FAIL single_byte cyc %0d: got %h want %h", k, obs_a[k], exp_a[k]);
      end
    end
    n_tests++;
    if (obs_a[65][13] !== 1'b1 || obs_a[65][7:0] !== 8'hB4 || obs_a[65][12:8] !== 5'd1) begin
      n_fail++;
      $display("FAIL single_byte_c65: got dv=%b do=%h cnt=%0d want dv=1 do=b4 cnt=1",
               obs_a[65][13], obs_a[65][7:0], obs_a[65][12:8]);
    end
    n_tests++;
    if (obs_a[81][15] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_byte_end: got frame_end=%b want 1 at cycle 81", obs_a[81][15]);
    end
    any_err = 1'b0;
    for (int k = 1; k <= n_cyc; k++) any_err |= obs_a[k][14];
    n_tests++;
    if (any_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_byte_noerr: got frame_err seen=%b want 0", any_err);
    end
  endtask

  task automatic test_max_bytes();
    int strobes;
    sym_q.delete(); push_syms(0, 0, 0, 0); push_syms(3, 3, 3, 3);
    sym_q.push_back(4'h1);
    run_frame(0, 0);
    strobes = 0;
    for (int k = 1; k <= n_cyc; k++) begin
      n_tests++;
      if (obs_a[k] !== exp_a[k]) begin
        n_fail++;
        $display("FAIL max_bytes cyc %0d: got %h want %h", k, obs_a[k], exp_a[k]);
      end
      strobes += int'(obs_a[k][13]);
    end
    n_tests++;
    if (strobes != 2) begin
      n_fail++;
      $display("FAIL max_bytes_strobes: got %0d want 2", strobes);
    end
    n_tests++;
    if (obs_a[129][15] !== 1'b1 || obs_a[129][13] !== 1'b1 || obs_a[129][7:0] !== 8'hFF) begin
      n_fail++;
      $display("FAIL max_bytes_c129: got fe=%b dv=%b do=%h want fe=1 dv=1 do=ff",
               obs_a[129][15], obs_a[129][13], obs_a[129][7:0]);
    end
  endtask

  task automatic test_missing_pulse();
    logic [7:0] prev_do;
    bit any_dv;
    prev_do = g_do;
    sym_q.delete(); sym_q.push_back(4'b0010); sym_q.push_back(4'b0100);
    run_frame(0, 0);
    any_dv = 1'b0;
    for (int k = 1; k <= n_cyc; k++) begin
      n_tests++;
      if (obs_a[k] !== exp_a[k]) begin
        n_fail++;
        $display("FAIL missing_pulse cyc %0d: got %h want %h", k, obs_a[k], exp_a[k]);
      end
      any_dv |= obs_a[k][13];
    end
    n_tests++;
    if (obs_a[49][14] !== 1'b1 || any_dv !== 1'b0 || obs_a[n_cyc][7:0] !== prev_do) begin
      n_fail++;
      $display("FAIL missing_pulse_err: got ferr=%b dv_seen=%b do=%h want 1 0 %h",
               obs_a[49][14], any_dv, obs_a[n_cyc][7:0], prev_do);
    end
  endtask

  task automatic test_double_pulse();
    sym_q.delete(); sym_q.push_back(4'b0100); sym_q.push_back(4'b0101);
    run_frame(0, 0);
    for (int k = 1; k <= n_cyc; k++) begin
      n_tests++;
      if (obs_a[k] !== exp_a[k]) begin
        n_fail++;
        $display("FAIL double_pulse cyc %0d: got %h want %h", k, obs_a[k], exp_a[k]);
      end
    end
    n_tests++;
    if (obs_a[33][14] !== 1'b1 || obs_a[33][16] !== 1'b0) begin
      n_fail++;
      $display("FAIL double_pulse_err: got ferr=%b busy=%b want 1 0",
               obs_a[33][14], obs_a[33][16]);
    end
  endtask

  task automatic test_reset_rearm();
    bit any_end;
    sym_q.delete(); push_syms(2, 3, 1, 0);
    run_frame(40, 0);
    any_end = 1'b0;
    for (int k = 1; k <= n_cyc; k++) begin
      n_tests++;
      if (obs_a[k] !== exp_a[k]) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: got %h want %h", k, obs_a[k], exp_a[k]);
      end
      any_end |= obs_a[k][15] | obs_a[k][14];
    end
    n_tests++;
    if (obs_a[41] !== 17'h0 || any_end !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got %h end_seen=%b want 0 0", obs_a[41], any_end);
    end
    sym_q.delete(); push_syms(0, 1, 2, 3);
    run_frame(0, 0);
    for (int k = 1; k <= n_cyc; k++) begin
      n_tests++;
      if (obs_a[k] !== exp_a[k]) begin
        n_fail++;
        $display("FAIL rearm cyc %0d: got %h want %h", k, obs_a[k], exp_a[k]);
      end
    end
    n_tests++;
    if (obs_a[65][13] !== 1'b1 || obs_a[65][7:0] !== 8'h1B) begin
      n_fail++;
      $display("FAIL rearm_byte: got dv=%b do=%h want dv=1 do=1b",
               obs_a[65][13], obs_a[65][7:0]);
    end
  endtask

  task automatic test_fen_while_busy();
    sym_q.delete(); push_syms(2, 3, 1, 0);
    run_frame(0, 20);
    for (int k = 1; k <= n_cyc; k++) begin
      n_tests++;
      if (obs_a[k] !== exp_a[k]) begin
        n_fail++;
        $display("FAIL fen_busy cyc %0d: got %h want %h", k, obs_a[k], exp_a[k]);
      end
    end
    n_tests++;
    if (obs_a[65][7:0] !== 8'hB4 || obs_a[81][15] !== 1'b1) begin
      n_fail++;
      $display("FAIL fen_busy_byte: got do=%h fe81=%b want b4 1",
               obs_a[65][7:0], obs_a[81][15]);
    end
  endtask

  task automatic test_random();
    int len, r;
    repeat (25) begin
      sym_q.delete();
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 19);
        if (r < 16)      sym_q.push_back(4'(1 << $urandom_range(0, 3)));
        else if (r < 18) sym_q.push_back(4'h0);
        else             sym_q.push_back(4'($urandom_range(0, 15)));
      end
      run_frame(0, 0);
      for (int k = 1; k <= n_cyc; k++) begin
        n_tests++;
        if (obs_a[k] !== exp_a[k]) begin
          n_fail++;
          $display("FAIL random cyc %0d: got %h want %h", k, obs_a[k], exp_a[k]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; Din = 1'b1; F_en = 1'b0;
    g_do = 8'h00; g_cnt = 5'd0;
    test_reset();
    test_single_byte();
    test_max_bytes();
    test_missing_pulse();
    test_double_pulse();
    test_reset_rearm();
    test_fen_while_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
